// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage branch target buffer.
package branch_predictor_pkg;

   // 2-bit direction counter encoding; bit 1 set means "predict taken"
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Fall-through increment (no delay slot)
   localparam logic [31:0] PC_INC = 32'd4;

   // Default table depth
   localparam int BP_ENTRIES = 16;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] next_ctr
);

   // Step toward taken/not-taken, holding at ST/SNT
   always_comb begin
      next_ctr = ctr;
      if (taken) begin
         if (ctr != ST) next_ctr = ctr + 2'd1;
      end else begin
         if (ctr != SNT) next_ctr = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup for the fetch
// PC, training and misprediction detection from the ID-stage resolution.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = 30 - IDX_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   input  logic        stall,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [IDX_W-1:0] if_idx, upd_idx;
   logic [TAG_W-1:0] if_tag, upd_tag;
   logic             if_hit, upd_hit, active;
   logic [31:0]      actual_next;
   logic [1:0]       ctr_next;
   logic             unused_pc_bits;

   assign if_idx  = if_pc[IDX_W+1:2];
   assign if_tag  = if_pc[31:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[31:IDX_W+2];

   // Instructions are word aligned; the low PC bits carry no information
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   // Lookup reads pre-edge contents; no bypass from a same-cycle update
   assign if_hit      = valid[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_INC;

   // Resolution against what IF predicted for this branch
   assign active      = upd_valid && !stall;
   assign actual_next = upd_taken ? upd_target : upd_pc + PC_INC;
   assign mispredict  = active && ((actual_next != upd_pred_target) ||
                                   (upd_taken != upd_pred_taken));
   assign redirect_pc = active ? actual_next : 32'd0;

   assign upd_hit = valid[upd_idx] && (tag_q[upd_idx] == upd_tag);

   bp_sat_counter u_ctr (
      .ctr      (ctr_q[upd_idx]),
      .taken    (upd_taken),
      .next_ctr (ctr_next)
   );

   // Valid bits, direction counters and statistics; cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid            <= '0;
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      end else if (active) begin
         stat_branches    <= stat_branches + 32'd1;
         stat_mispredicts <= stat_mispredicts + 32'(mispredict);
         if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_next;
         end else if (upd_taken) begin
            valid[upd_idx] <= 1'b1;
            ctr_q[upd_idx] <= WT;
         end
      end
   end

   // Tag/target payload: only meaningful under valid, so no reset needed.
   // A taken update either refreshes a hit (same tag) or allocates a miss.
   always_ff @(posedge clk) begin
      if (active && upd_taken) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each cycle pushes the expected
// outputs when stimulus is applied and pops/compares them once settled.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = 32'h100;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [31:0] upd_pred_target = '0;
   logic        stall = 1'b0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      string       nm;
      logic [31:0] v;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .stall            (stall),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] observe(input string nm);
      case (nm)
         "pred_taken":  return {31'd0, pred_taken};
         "pred_target": return pred_target;
         "mispredict":  return {31'd0, mispredict};
         "redirect_pc": return redirect_pc;
         "branches":    return stat_branches;
         "mispreds":    return stat_mispredicts;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   // One cycle: drive at negedge, queue expectations, compare 1 time unit later.
   // Stats expectations are the values before this cycle's clock edge.
   task automatic cyc(input logic r, input logic [31:0] pc_if,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic upt, input logic [31:0] upg,
                      input logic st,
                      input logic e_pt, input logic [31:0] e_ptg,
                      input logic e_mp, input logic [31:0] e_rd,
                      input logic [31:0] e_b, input logic [31:0] e_m);
      exp_t e;
      @(negedge clk);
      rst_n           = r;
      if_pc           = pc_if;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_taken       = ut;
      upd_target      = utg;
      upd_pred_taken  = upt;
      upd_pred_target = upg;
      stall           = st;
      exp_q.push_back('{"pred_taken",  {31'd0, e_pt}});
      exp_q.push_back('{"pred_target", e_ptg});
      exp_q.push_back('{"mispredict",  {31'd0, e_mp}});
      exp_q.push_back('{"redirect_pc", e_rd});
      exp_q.push_back('{"branches",    e_b});
      exp_q.push_back('{"mispreds",    e_m});
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.nm, observe(e.nm), e.v);
      end
   endtask

   initial begin
      // Reset state
      cyc(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 32'h104, 0, 32'h0,   0, 0);
      // First taken branch: miss, mispredict, allocate (ctr=WT); no same-cycle bypass
      cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0,  0, 32'h104, 1, 32'h200, 0, 0);
      // Three correctly predicted taken updates: WT -> ST, saturates
      cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0,  1, 32'h200, 0, 32'h200, 1, 1);
      cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0,  1, 32'h200, 0, 32'h200, 2, 1);
      cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0,  1, 32'h200, 0, 32'h200, 3, 1);
      // Not taken: ST -> WT, still predicts taken
      cyc(1, 32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 0,  1, 32'h200, 1, 32'h104, 4, 1);
      // Not taken: WT -> WNT
      cyc(1, 32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, 0,  1, 32'h200, 1, 32'h104, 5, 2);
      // Not taken, predicted correctly: WNT -> SNT
      cyc(1, 32'h100, 1, 32'h100, 0, 32'h200, 0, 32'h104, 0,  0, 32'h104, 0, 32'h104, 6, 3);
      // Not taken at SNT: must hold at SNT
      cyc(1, 32'h100, 1, 32'h100, 0, 32'h200, 0, 32'h104, 0,  0, 32'h104, 0, 32'h104, 7, 3);
      // Taken from SNT -> WNT, so still predicts fall-through next cycle
      cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0,  0, 32'h104, 1, 32'h200, 8, 3);
      cyc(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 32'h104, 0, 32'h0,   9, 4);
      // Alias at 0x140 (same index, different tag): miss then taken allocate
      cyc(1, 32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0,  0, 32'h144, 1, 32'h300, 9, 4);
      cyc(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 32'h104, 0, 32'h0,  10, 5);
      // Miss not-taken at 0x180 (same index): no table write
      cyc(1, 32'h140, 1, 32'h180, 0, 32'h0,   0, 32'h184, 0,  1, 32'h300, 0, 32'h184, 10, 5);
      // Direction right, target wrong: mispredict, target refreshed
      cyc(1, 32'h140, 1, 32'h140, 1, 32'h340, 1, 32'h300, 0,  1, 32'h300, 1, 32'h340, 11, 5);
      cyc(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 32'h340, 0, 32'h0,  12, 6);
      // 32-bit wrap of PC+4 for both lookup and resolution
      cyc(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0, 12, 6);
      cyc(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0, 13, 6);
      // Stall: no resolution outputs, no table or stats change
      cyc(1, 32'h140, 1, 32'h140, 1, 32'h777, 0, 32'h144, 1,  1, 32'h340, 0, 32'h0,  13, 6);
      // upd_valid=0: inputs ignored
      cyc(1, 32'h140, 0, 32'h140, 1, 32'h888, 0, 32'h144, 0,  1, 32'h340, 0, 32'h0,  13, 6);
      cyc(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 32'h340, 0, 32'h0,  13, 6);
      // Mid-run reset: cleared before any clock edge
      cyc(0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 32'h144, 0, 32'h0,   0, 0);
      // Training resumes from reset state
      cyc(1, 32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0,  0, 32'h144, 1, 32'h300, 0, 0);
      cyc(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 32'h300, 0, 32'h0,   1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage direct-mapped branch target buffer with 2-bit saturating direction counters.
- Predicts the next PC for the fetch address every cycle.
- Trained by the ID-stage branch-condition result (Z) and the resolved target.
- Flags mispredictions and supplies the corrective PC for the IF/ID flush.
- Keeps 32-bit performance counters for branches resolved and mispredictions.

Parameters:
ENTRIES, 16, number of table entries; power of two, at least 2
IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2]
TAG_W, 26, 30-IDX_W; tag = pc[31:IDX_W+2]

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_pc  in  32  current fetch PC
pred_taken  out  1  prediction for if_pc: taken
pred_target  out  32  predicted next PC (target if taken, else if_pc+4)
upd_valid  in  1  ID holds a resolved conditional branch this cycle
upd_pc  in  32  PC of that branch
upd_taken  in  1  resolved direction (branch-test Z)
upd_target  in  32  resolved branch target
upd_pred_taken  in  1  prediction made for this branch in IF, carried through IF/ID
upd_pred_target  in  32  predicted next PC carried through IF/ID
stall  in  1  ID stalled; suppresses update and counting
mispredict  out  1  flush IF/ID and redirect fetch
redirect_pc  out  32  correct next PC when mispredict=1
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  misprediction count

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[2].
- Reset (async, rst_n=0):
  - all valid=0, all ctr=2'b01, stat counters=0.
  - Outputs: pred_taken=0, pred_target=if_pc+4, mispredict=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
- Resolution (combinational, active when upd_valid & ~stall):
  - Actual next PC = upd_taken ? upd_target : upd_pc+4.
  - mispredict = 1 when actual next PC != upd_pred_target, or upd_taken != upd_pred_taken.
  - redirect_pc = actual next PC; redirect_pc = 0 when not active.
  - When not active: mispredict=0.
- Update (rising clk edge, active when upd_valid & ~stall):
  - Hit, taken: ctr saturates up (max 11), target <= upd_target.
  - Hit, not taken: ctr saturates down (min 00), target unchanged.
  - Miss, taken: allocate or overwrite the entry: valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no table write.
  - stat_branches += 1; stat_mispredicts += mispredict. Both wrap at 2^32.
- Simultaneous lookup and update to the same index: lookup returns the pre-edge contents; no bypass. The new value is visible the next cycle.
- Alias: a different PC with the same index but a different tag misses. A taken update replaces the entry.
- stall=1: no table or counter change. Lookup still works.
- upd_valid=0: inputs ignored.
- Reset mid-run: table and counters clear immediately and asynchronously. Training resumes from reset state after rst_n deasserts.
- No delay slot; fall-through is PC+4. 32-bit adds discard carry (0xFFFFFFFC+4 = 0).

Decomposition:
- Shared package:
  - ctr encoding constants SNT=00, WNT=01, WT=10, ST=11.
  - PC_INC=4.
  - ENTRIES default.
- One sub-module, bp_sat_counter: 2-bit next-state function, inputs ctr and taken, output next ctr.
- Tables are flat register arrays in the top module.

Test Plan:
1. Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, stat counters 0, mispredict=0.
2. Update pc=0x100, taken, target=0x200, pred_taken=0 -> mispredict=1, redirect_pc=0x200. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x200.
3. Train 0x100 taken three times, then not taken once -> ctr goes 11 then 10, prediction still taken. Two more not-taken updates -> ctr 00, predicts 0x104. Counters must never wrap.
4. Alias: 0x100 trained, then taken update at 0x140 (ENTRIES=16, same index) with target 0x300 -> lookup 0x100 misses (0x104), lookup 0x140 returns 0x300.
5. Correct prediction with wrong target: pred_taken=1, pred_target=0x200, actual taken to 0x240 -> mispredict=1, redirect_pc=0x240, target updated.
6. stall=1 with upd_valid=1 -> no table change, stats unchanged, mispredict=0. Assert rst_n low mid-sequence -> all entries invalid immediately, stats=0.
